// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
// Select encodings, FSM states and flag-bit positions.
package alu_pkg;

    localparam logic [3:0] s_Add               = 4'b0100;
    localparam logic [3:0] s_Subtract          = 4'b0101;
    localparam logic [3:0] s_MultiplyU         = 4'b0110;
    localparam logic [3:0] s_Not               = 4'b1000;
    localparam logic [3:0] s_Or                = 4'b1001;
    localparam logic [3:0] s_And               = 4'b1010;
    localparam logic [3:0] s_Xor               = 4'b1011;
    localparam logic [3:0] s_ShiftLeft         = 4'b1100;
    localparam logic [3:0] s_ShiftRightLogical = 4'b1101;
    localparam logic [3:0] s_ShiftRightArith   = 4'b1110;
    localparam logic [3:0] s_PassThroughA      = 4'b1111;

    typedef enum logic {
        st_idle,
        st_mul
    } state_t;

    localparam int f_Carry    = 0;
    localparam int f_Zero     = 1;
    localparam int f_Negative = 2;
    localparam int f_Overflow = 3;
    localparam int FlagCount  = 4;

endpackage

// File: rtl/seq_alu_multiplier.sv
// shift_add_multiplier: unsigned radix-2 multiplier.
// One partial-product add per cycle; Done marks the final step.
module shift_add_multiplier #(
    parameter int DataLength = 8
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic [DataLength-1:0]     OperandA,
    input  logic [DataLength-1:0]     OperandB,
    output logic                      Done,
    output logic [2*DataLength-1:0]   Product
);

    localparam int CW = $clog2(DataLength);

    logic                    busy;
    logic [CW-1:0]           count;
    logic [DataLength-1:0]   mcand;
    logic [2*DataLength-1:0] acc;
    logic [2*DataLength-1:0] acc_next;
    logic [DataLength:0]     partial;

    // Add the multiplicand into the high half when the current
    // multiplier bit (acc LSB) is set, then shift right by one.
    always_comb begin
        partial = {1'b0, acc[2*DataLength-1:DataLength]};
        if (acc[0]) begin
            partial = partial + {1'b0, mcand};
        end
        acc_next = {partial, acc[DataLength-1:1]};
    end

    assign Done    = busy && (count == CW'(DataLength - 1));
    assign Product = acc_next;

    // Operand latch and iteration counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            busy  <= 1'b0;
            count <= '0;
            mcand <= '0;
            acc   <= '0;
        end else if (Start) begin
            busy  <= 1'b1;
            count <= '0;
            mcand <= OperandA;
            acc   <= {{DataLength{1'b0}}, OperandB};
        end else if (busy) begin
            acc   <= acc_next;
            count <= count + CW'(1);
            if (Done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered valid/ready ALU with a multi-cycle
// unsigned multiply and single-cycle logic/arith/shift ops.
module seq_alu
    import alu_pkg::*;
#(
    parameter int DataLength = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [DataLength-1:0] InputA,
    input  logic [DataLength-1:0] InputB,
    input  logic [3:0]            Select,
    input  logic                  CarryIn,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [DataLength-1:0] OutputResult,
    output logic [DataLength-1:0] OutputHigh,
    output logic                  CarryOut,
    output logic                  Zero,
    output logic                  Negative,
    output logic                  Overflow
);

    localparam int N = DataLength;

    state_t state;
    state_t state_next;

    logic                 accept;
    logic                 is_mul;
    logic                 mul_done;
    logic [2*N-1:0]       product;

    logic [N:0]           add_sum;
    logic [N:0]           sub_sum;
    logic [N:0]           shl_w;
    logic [N:0]           shr_w;
    logic [N:0]           sra_w;
    logic                 amt_zero;
    logic [N-1:0]         sc_r;
    logic                 sc_c;
    logic                 sc_v;
    logic [FlagCount-1:0] sc_flags;
    logic [FlagCount-1:0] mul_flags;

    logic                 valid_q;
    logic [N-1:0]         res_q;
    logic [N-1:0]         high_q;
    logic [FlagCount-1:0] flags_q;

    assign is_mul  = (Select == s_MultiplyU);
    assign InReady = !Reset && (state == st_idle)
                  && (!valid_q || OutReady);
    assign accept  = InValid && InReady;

    // Single-cycle unit; one extra bit in each shift vector
    // catches the last bit shifted out.
    always_comb begin
        add_sum  = {1'b0, InputA} + {1'b0, InputB}
                 + {{N{1'b0}}, CarryIn};
        sub_sum  = {1'b0, InputA} + {1'b0, ~InputB}
                 + {{N{1'b0}}, CarryIn};
        shl_w    = {1'b0, InputA} << InputB;
        shr_w    = {InputA, 1'b0} >> InputB;
        sra_w    = $signed({InputA, 1'b0}) >>> InputB;
        amt_zero = (InputB == '0);
        sc_r     = '0;
        sc_c     = CarryIn;
        sc_v     = 1'b0;
        case (Select)
            s_Add: begin
                sc_r = add_sum[N-1:0];
                sc_c = add_sum[N];
                sc_v = (InputA[N-1] == InputB[N-1])
                    && (sc_r[N-1] != InputA[N-1]);
            end
            s_Subtract: begin
                sc_r = sub_sum[N-1:0];
                sc_c = sub_sum[N];
                sc_v = (InputA[N-1] != InputB[N-1])
                    && (sc_r[N-1] != InputA[N-1]);
            end
            s_Not:  sc_r = ~InputA;
            s_Or:   sc_r = InputA | InputB;
            s_And:  sc_r = InputA & InputB;
            s_Xor:  sc_r = InputA ^ InputB;
            s_ShiftLeft: begin
                sc_r = amt_zero ? InputA : shl_w[N-1:0];
                sc_c = amt_zero ? CarryIn : shl_w[N];
            end
            s_ShiftRightLogical: begin
                sc_r = amt_zero ? InputA : shr_w[N:1];
                sc_c = amt_zero ? CarryIn : shr_w[0];
            end
            s_ShiftRightArith: begin
                sc_r = amt_zero ? InputA : sra_w[N:1];
                sc_c = amt_zero ? CarryIn : sra_w[0];
            end
            s_PassThroughA: sc_r = InputA;
            default: sc_r = '0;
        endcase
        sc_flags              = '0;
        sc_flags[f_Carry]     = sc_c;
        sc_flags[f_Zero]      = (sc_r == '0);
        sc_flags[f_Negative]  = sc_r[N-1];
        sc_flags[f_Overflow]  = sc_v;
    end

    // Flags for a finished multiply come from the full product.
    always_comb begin
        mul_flags              = '0;
        mul_flags[f_Zero]      = (product == '0);
        mul_flags[f_Negative]  = product[2*N-1];
        mul_flags[f_Overflow]  = |product[2*N-1:N];
    end

    shift_add_multiplier #(
        .DataLength (N)
    ) u_mul (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (accept && is_mul),
        .OperandA (InputA),
        .OperandB (InputB),
        .Done     (mul_done),
        .Product  (product)
    );

    // FSM state register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= st_idle;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: leave IDLE on a multiply, return on Done.
    always_comb begin
        state_next = state;
        unique case (state)
            st_idle: if (accept && is_mul) state_next = st_mul;
            st_mul:  if (mul_done) state_next = st_idle;
        endcase
    end

    // Output stage: load on accept or multiply finish,
    // otherwise hold until the consumer takes it.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            high_q  <= '0;
            flags_q <= '0;
        end else if (accept && !is_mul) begin
            valid_q <= 1'b1;
            res_q   <= sc_r;
            high_q  <= '0;
            flags_q <= sc_flags;
        end else if (state == st_mul && mul_done) begin
            valid_q <= 1'b1;
            res_q   <= product[N-1:0];
            high_q  <= product[2*N-1:N];
            flags_q <= mul_flags;
        end else if (valid_q && OutReady) begin
            valid_q <= 1'b0;
        end
    end

    assign OutValid     = valid_q;
    assign OutputResult = res_q;
    assign OutputHigh   = high_q;
    assign CarryOut     = flags_q[f_Carry];
    assign Zero         = flags_q[f_Zero];
    assign Negative     = flags_q[f_Negative];
    assign Overflow     = flags_q[f_Overflow];

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu with directed
// corner cases and a randomized phase.
module tb_seq_alu;

    localparam int N = 8;

    typedef struct packed {
        logic [N-1:0] r;
        logic [N-1:0] hi;
        logic         c;
        logic         z;
        logic         n;
        logic         v;
    } exp_t;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         InValid;
    logic         InReady;
    logic [N-1:0] InputA;
    logic [N-1:0] InputB;
    logic [3:0]   Select;
    logic         CarryIn;
    logic         OutValid;
    logic         OutReady;
    logic [N-1:0] OutputResult;
    logic [N-1:0] OutputHigh;
    logic         CarryOut;
    logic         Zero;
    logic         Negative;
    logic         Overflow;

    int   tests = 0;
    int   fails = 0;
    int   stalls = 0;
    exp_t sb[$];

    seq_alu #(.DataLength(N)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .InValid      (InValid),
        .InReady      (InReady),
        .InputA       (InputA),
        .InputB       (InputB),
        .Select       (Select),
        .CarryIn      (CarryIn),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .OutputResult (OutputResult),
        .OutputHigh   (OutputHigh),
        .CarryOut     (CarryOut),
        .Zero         (Zero),
        .Negative     (Negative),
        .Overflow     (Overflow)
    );

    always #5 Clock = ~Clock;

    // Reference model built from integer arithmetic.
    function automatic exp_t model(input logic [3:0] sel,
                                   input int a, input int b,
                                   input bit cin);
        exp_t   m;
        int     mask = (1 << N) - 1;
        int     half = 1 << (N - 1);
        int     sa = (a >= half) ? a - (1 << N) : a;
        int     sb2 = (b >= half) ? b - (1 << N) : b;
        int     r = 0;
        int     c = int'(cin);
        int     v = 0;
        int     hi = 0;
        int     s;
        int     k;
        longint p = 0;
        case (sel)
            4'h4: begin
                s = a + b + int'(cin);
                r = s & mask;
                c = s >> N;
                s = sa + sb2 + int'(cin);
                v = int'(s > half - 1 || s < -half);
            end
            4'h5: begin
                s = a + (~b & mask) + int'(cin);
                r = s & mask;
                c = s >> N;
                s = sa - sb2 - 1 + int'(cin);
                v = int'(s > half - 1 || s < -half);
            end
            4'h6: begin
                p = longint'(a) * longint'(b);
                r = int'(p) & mask;
                hi = int'(p >> N);
                c = 0;
                v = int'(hi != 0);
            end
            4'h8: r = ~a & mask;
            4'h9: r = a | b;
            4'hA: r = a & b;
            4'hB: r = a ^ b;
            4'hC: begin
                if (b == 0) r = a;
                else begin
                    r = (b >= N) ? 0 : (a << b) & mask;
                    c = (b <= N) ? (a >> (N - b)) & 1 : 0;
                end
            end
            4'hD: begin
                if (b == 0) r = a;
                else begin
                    r = (b >= N) ? 0 : a >> b;
                    c = (b <= N) ? (a >> (b - 1)) & 1 : 0;
                end
            end
            4'hE: begin
                if (b == 0) r = a;
                else begin
                    k = (b > N) ? N : b;
                    r = (sa >>> k) & mask;
                    c = (b <= N) ? (sa >>> (b - 1)) & 1
                                 : int'(sa < 0);
                end
            end
            4'hF: r = a;
            default: r = 0;
        endcase
        m.r  = N'(r);
        m.hi = N'(hi);
        m.c  = c[0];
        m.v  = v[0];
        m.z  = (sel == 4'h6) ? (p == 0) : (r == 0);
        m.n  = (sel == 4'h6) ? hi[N-1] : r[N-1];
        return m;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Present one op and wait (bounded) for its accept edge.
    task automatic issue(input logic [3:0] sel, input int a,
                         input int b, input bit cin,
                         input bit push);
        int n = 0;
        InValid = 1'b1;
        Select  = sel;
        InputA  = N'(a);
        InputB  = N'(b);
        CarryIn = cin;
        forever begin
            @(negedge Clock);
            if (InReady) break;
            n++;
            stalls++;
            if (n > 60) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: sel %0h", sel);
                InValid = 1'b0;
                return;
            end
            step();
            if (n > 2) OutReady = 1'b1;
        end
        if (push) sb.push_back(model(sel, a, b, cin));
        step();
        InValid = 1'b0;
    endtask

    // Pop and compare on every transfer; check holds under stall.
    task automatic monitor();
        exp_t e;
        exp_t g;
        exp_t snap = '0;
        bit   hold_v = 1'b0;
        forever begin
            @(negedge Clock);
            g = {OutputResult, OutputHigh, CarryOut,
                 Zero, Negative, Overflow};
            if (Reset) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    tests++;
                    if (!OutValid || g !== snap) begin
                        fails++;
                        $display("FAIL hold: got v%0b %h want %h",
                                 OutValid, g, snap);
                    end
                end
                if (OutValid && OutReady) begin
                    tests++;
                    hold_v = 1'b0;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL sb_extra: got %h", g);
                    end else begin
                        e = sb.pop_front();
                        if (g !== e) begin
                            fails++;
                            $display("FAIL result: got %h want %h",
                                     g, e);
                        end
                    end
                end else if (OutValid) begin
                    snap   = g;
                    hold_v = 1'b1;
                end else begin
                    hold_v = 1'b0;
                end
            end
        end
    endtask

    task automatic drain();
        OutReady = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            step();
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int lat;
        logic [3:0] sel;
        int a;
        int b;
        Reset    = 1'b1;
        InValid  = 1'b0;
        InputA   = '0;
        InputB   = '0;
        Select   = '0;
        CarryIn  = 1'b0;
        OutReady = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge Clock);
        @(negedge Clock);
        chk("rst_inready", InReady, 0);
        chk("rst_outvalid", OutValid, 0);
        chk("rst_result", OutputResult, 0);
        chk("rst_high", OutputHigh, 0);
        chk("rst_flags", {Overflow, Negative, Zero, CarryOut}, 0);
        step();
        Reset    = 1'b0;
        OutReady = 1'b1;

        issue(4'h4, 'h7F, 'h01, 1'b0, 1'b1);
        @(negedge Clock);
        chk("add_valid", OutValid, 1);
        chk("add_r", OutputResult, 'h80);
        chk("add_vnzc", {Overflow, Negative, Zero, CarryOut},
            4'b1100);
        step();

        issue(4'h5, 'h05, 'h05, 1'b1, 1'b1);
        @(negedge Clock);
        chk("sub0_r", OutputResult, 'h00);
        chk("sub0_zc", {Zero, CarryOut}, 2'b11);
        step();
        issue(4'h5, 'h03, 'h05, 1'b1, 1'b1);
        @(negedge Clock);
        chk("subn_r", OutputResult, 'hFE);
        chk("subn_c", CarryOut, 0);
        step();

        issue(4'h6, 'hFF, 'hFF, 1'b0, 1'b1);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clock);
            if (OutValid) begin
                lat = i;
                break;
            end
            chk("mul_inready", InReady, 0);
        end
        chk("mul_latency", lat, 9);
        chk("mul_high", OutputHigh, 'hFE);
        chk("mul_r", OutputResult, 'h01);
        chk("mul_ov", Overflow, 1);
        step();

        issue(4'hE, 'h81, 1, 1'b0, 1'b1);
        @(negedge Clock);
        chk("sra1_r", OutputResult, 'hC0);
        chk("sra1_c", CarryOut, 1);
        step();
        issue(4'hC, 'h81, 9, 1'b0, 1'b1);
        @(negedge Clock);
        chk("shl9_r", OutputResult, 'h00);
        step();
        issue(4'hD, 'h81, 0, 1'b1, 1'b1);
        @(negedge Clock);
        chk("shr0_r", OutputResult, 'h81);
        chk("shr0_c", CarryOut, 1);
        step();

        OutReady = 1'b0;
        issue(4'h4, 'h12, 'h34, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            chk("bp_inready", InReady, 0);
        end
        chk("bp_valid", OutValid, 1);
        chk("bp_r", OutputResult, 'h46);
        step();
        OutReady = 1'b1;
        stalls   = 0;
        for (int i = 0; i < 4; i++) begin
            issue(4'h4, 16 * i + 1, 3 * i, i[0], 1'b1);
        end
        chk("stream_stalls", stalls, 0);
        @(negedge Clock);
        chk("stream_last_valid", OutValid, 1);
        step();
        drain();

        issue(4'h6, 'hA5, 'h3C, 1'b0, 1'b0);
        repeat (2) begin
            @(negedge Clock);
            chk("abort_busy", InReady, 0);
        end
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        @(negedge Clock);
        chk("abort_outvalid", OutValid, 0);
        chk("abort_inready", InReady, 1);
        repeat (12) @(negedge Clock);
        chk("abort_quiet", OutValid, 0);
        step();

        for (int i = 0; i < 300; i++) begin
            OutReady = ($urandom_range(0, 3) != 0);
            sel = 4'($urandom_range(0, 15));
            a = $urandom_range(0, 255);
            if (sel >= 4'hC && $urandom_range(0, 1) == 1)
                b = $urandom_range(0, 12);
            else
                b = $urandom_range(0, 255);
            issue(sel, a, b, 1'($urandom_range(0, 1)), 1'b1);
            if ($urandom_range(0, 7) == 0) step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
